// File: rtl/exc_pkg.sv
// Shared definitions for the commit-point exception unit: cause codes,
// CP0 register indices, FSM states and the flag bundle.
package exc_pkg;

    localparam logic [31:0] EXC_INT  = 32'h0000_0001;
    localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
    localparam logic [31:0] EXC_ADES = 32'h0000_0005;
    localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
    localparam logic [31:0] EXC_BP   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI   = 32'h0000_000a;
    localparam logic [31:0] EXC_OV   = 32'h0000_000c;
    localparam logic [31:0] EXC_TR   = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET = 32'h0000_000e;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    typedef enum logic [1:0] {IDLE, REPORT, DRAIN} state_e;
    typedef enum logic [1:0] {BAD_NONE, BAD_PC, BAD_MEM} bad_sel_e;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic trap;
        logic syscall;
        logic brk;
        logic adel_ld;
        logic ades;
        logic eret;
    } exc_flags_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder: picks the single exception to report and which
// address (if any) is the faulting one.
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic        int_hit,
    input  exc_flags_t  flags,
    output logic [31:0] code,
    output bad_sel_e    bad_sel
);

    always_comb begin
        code    = '0;
        bad_sel = BAD_NONE;
        if (int_hit) begin
            code = EXC_INT;
        end else if (flags.adel_if) begin
            code    = EXC_ADEL;
            bad_sel = BAD_PC;
        end else if (flags.ri) begin
            code = EXC_RI;
        end else if (flags.ov) begin
            code = EXC_OV;
        end else if (flags.trap) begin
            code = EXC_TR;
        end else if (flags.syscall) begin
            code = EXC_SYS;
        end else if (flags.brk) begin
            code = EXC_BP;
        end else if (flags.adel_ld) begin
            code    = EXC_ADEL;
            bad_sel = BAD_MEM;
        end else if (flags.ades) begin
            code    = EXC_ADES;
            bad_sel = BAD_MEM;
        end else if (flags.eret) begin
            code = EXC_ERET;
        end
    end

endmodule

// File: rtl/exception_unit.sv
// Commit-point exception detector: bypasses pending CP0 writes, arbitrates
// exceptions, emits a one-cycle flush/redirect and masks while draining.
module exception_unit
    import exc_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic [31:0] pc_i,
    input  logic        in_delayslot_i,
    input  logic        adel_if_i,
    input  logic        ri_i,
    input  logic        ov_i,
    input  logic        trap_i,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        adel_ld_i,
    input  logic        ades_st_i,
    input  logic        eret_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic [31:0] bad_addr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        int_pending_q, int_pending_d;
    logic [31:0] excepttype_q, excepttype_d;
    logic [31:0] cia_q, cia_d;
    logic [31:0] bad_addr_q, bad_addr_d;
    logic        ds_q, ds_d;
    logic        flush_q, flush_d;
    logic [31:0] new_pc_q, new_pc_d;

    logic [31:0] eff_status, eff_cause, eff_epc;
    logic        int_req, int_hit, accept, exc_valid;
    logic [31:0] code;
    bad_sel_e    bad_sel;
    exc_flags_t  flags;
    logic        unused_bits;

    // Cause writes from software only reach the two soft-interrupt bits.
    always_comb begin
        eff_status = status_i;
        eff_cause  = cause_i;
        eff_epc    = epc_i;
        if (cp0_we_i && cp0_waddr_i == CP0_STATUS) eff_status = cp0_wdata_i;
        if (cp0_we_i && cp0_waddr_i == CP0_CAUSE)  eff_cause[9:8] = cp0_wdata_i[9:8];
        if (cp0_we_i && cp0_waddr_i == CP0_EPC)    eff_epc = cp0_wdata_i;
    end

    assign unused_bits = ^{eff_status[31:16], eff_cause[31:16], eff_cause[7:0]};

    assign int_req = eff_status[0] & ~eff_status[1] & (|(eff_cause[15:8] & eff_status[15:8]));
    assign int_hit = int_pending_q | int_req;
    assign accept  = (state_q == IDLE) && valid_i && !stall_i;
    assign flags   = '{adel_if: adel_if_i, ri: ri_i, ov: ov_i, trap: trap_i,
                       syscall: syscall_i, brk: break_i, adel_ld: adel_ld_i,
                       ades: ades_st_i, eret: eret_i};

    exc_prio_enc u_prio (
        .int_hit (int_hit),
        .flags   (flags),
        .code    (code),
        .bad_sel (bad_sel)
    );

    assign exc_valid = accept && (code != '0);

    // Pending interrupt follows int_req, but is consumed once reported.
    assign int_pending_d = int_req & ~(accept & int_hit);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        excepttype_d = '0;
        flush_d      = 1'b0;
        cia_d        = cia_q;
        bad_addr_d   = bad_addr_q;
        ds_d         = ds_q;
        new_pc_d     = new_pc_q;
        case (state_q)
            IDLE: begin
                if (exc_valid) begin
                    state_d      = REPORT;
                    excepttype_d = code;
                    flush_d      = 1'b1;
                    cia_d        = pc_i;
                    ds_d         = in_delayslot_i;
                    new_pc_d     = (code == EXC_ERET) ? eff_epc : EXC_VECTOR;
                    case (bad_sel)
                        BAD_PC:  bad_addr_d = pc_i;
                        BAD_MEM: bad_addr_d = mem_addr_i;
                        default: bad_addr_d = '0;
                    endcase
                end
            end
            REPORT: begin
                state_d = DRAIN;
                cnt_d   = DRAIN_LOAD;
            end
            DRAIN: begin
                if (cnt_q == 4'd0) state_d = IDLE;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            int_pending_q <= 1'b0;
            excepttype_q  <= '0;
            cia_q         <= '0;
            bad_addr_q    <= '0;
            ds_q          <= 1'b0;
            flush_q       <= 1'b0;
            new_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            int_pending_q <= int_pending_d;
            excepttype_q  <= excepttype_d;
            cia_q         <= cia_d;
            bad_addr_q    <= bad_addr_d;
            ds_q          <= ds_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
        end
    end

    assign excepttype_o        = excepttype_q;
    assign current_inst_addr_o = cia_q;
    assign bad_addr_o          = bad_addr_q;
    assign is_in_delayslot_o   = ds_q;
    assign flush_o             = flush_q;
    assign new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: a vector table for single-instruction
// exceptions plus hand sequences for interrupts, drain, reset and stall.
module tb_exception_unit;

    localparam logic [31:0] VEC   = 32'hBFC0_0380;
    localparam logic [31:0] EPC_I = 32'h8000_1000;

    localparam logic [8:0] F_ADELIF = 9'h100;
    localparam logic [8:0] F_RI     = 9'h080;
    localparam logic [8:0] F_OV     = 9'h040;
    localparam logic [8:0] F_TRAP   = 9'h020;
    localparam logic [8:0] F_SYS    = 9'h010;
    localparam logic [8:0] F_BRK    = 9'h008;
    localparam logic [8:0] F_ADELLD = 9'h004;
    localparam logic [8:0] F_ADES   = 9'h002;
    localparam logic [8:0] F_ERET   = 9'h001;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, stall_i, in_delayslot_i;
    logic [31:0] pc_i, mem_addr_i, status_i, cause_i, epc_i, cp0_wdata_i;
    logic        adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ld_i, ades_st_i, eret_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    exception_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .valid_i             (valid_i),
        .stall_i             (stall_i),
        .pc_i                (pc_i),
        .in_delayslot_i      (in_delayslot_i),
        .adel_if_i           (adel_if_i),
        .ri_i                (ri_i),
        .ov_i                (ov_i),
        .trap_i              (trap_i),
        .syscall_i           (syscall_i),
        .break_i             (break_i),
        .adel_ld_i           (adel_ld_i),
        .ades_st_i           (ades_st_i),
        .eret_i              (eret_i),
        .mem_addr_i          (mem_addr_i),
        .status_i            (status_i),
        .cause_i             (cause_i),
        .epc_i               (epc_i),
        .cp0_we_i            (cp0_we_i),
        .cp0_waddr_i         (cp0_waddr_i),
        .cp0_wdata_i         (cp0_wdata_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .bad_addr_o          (bad_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o)
    );

    typedef struct {
        logic [8:0]  flags;
        logic [31:0] pc;
        logic [31:0] mem;
        logic        ds;
        logic [31:0] status;
        logic [31:0] cause;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exp_code;
        logic [31:0] exp_bad;
        logic [31:0] exp_npc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [8:0] f, logic [31:0] pc, logic [31:0] mem, logic ds,
                                logic [31:0] st, logic [31:0] ca, logic we, logic [4:0] wa,
                                logic [31:0] wd, logic [31:0] code, logic [31:0] bad,
                                logic [31:0] npc);
        vec_t v;
        v.flags = f; v.pc = pc; v.mem = mem; v.ds = ds; v.status = st; v.cause = ca;
        v.we = we; v.waddr = wa; v.wdata = wd;
        v.exp_code = code; v.exp_bad = bad; v.exp_npc = npc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        valid_i = 0; stall_i = 0; pc_i = '0; in_delayslot_i = 0; mem_addr_i = '0;
        {adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ld_i, ades_st_i, eret_i} = '0;
        status_i = '0; cause_i = '0; epc_i = EPC_I;
        cp0_we_i = 0; cp0_waddr_i = '0; cp0_wdata_i = '0;
    endtask

    task automatic drain_wait();
        clear_inputs();
        repeat (4) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // single-instruction vectors: flags, pc, mem, ds, status, cause, we, waddr, wdata -> code, bad, new_pc
        vecs.push_back(mk(F_SYS, 32'hBFC00100, 32'h0, 0, 0, 0, 0, 0, 0, 32'h08, 32'h0, VEC));
        vecs.push_back(mk(F_ADELLD, 32'h80000010, 32'h80000003, 1, 0, 0, 0, 0, 0, 32'h04, 32'h80000003, VEC));
        vecs.push_back(mk(F_ERET, 32'h80000020, 32'h0, 0, 0, 0, 1, 5'd14, 32'hBFC00200, 32'h0e, 32'h0, 32'hBFC00200));
        vecs.push_back(mk(F_ERET, 32'h80000024, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0e, 32'h0, EPC_I));
        vecs.push_back(mk(F_ERET, 32'h80000028, 32'h0, 0, 0, 0, 1, 5'd12, 32'h0, 32'h0e, 32'h0, EPC_I));
        vecs.push_back(mk(F_ERET, 32'h8000002c, 32'h0, 0, 0, 0, 1, 5'd13, 32'hBFC00200, 32'h0e, 32'h0, EPC_I));
        vecs.push_back(mk(F_ADELIF | F_RI, 32'h80000031, 32'h11111111, 0, 0, 0, 0, 0, 0, 32'h04, 32'h80000031, VEC));
        vecs.push_back(mk(F_RI | F_OV, 32'h80000040, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0a, 32'h0, VEC));
        vecs.push_back(mk(F_OV | F_TRAP, 32'h80000044, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0c, 32'h0, VEC));
        vecs.push_back(mk(F_TRAP | F_SYS, 32'h80000048, 32'h0, 1, 0, 0, 0, 0, 0, 32'h0d, 32'h0, VEC));
        vecs.push_back(mk(F_SYS | F_BRK, 32'h8000004c, 32'h0, 0, 0, 0, 0, 0, 0, 32'h08, 32'h0, VEC));
        vecs.push_back(mk(F_BRK | F_ADELLD, 32'h80000050, 32'h12345678, 0, 0, 0, 0, 0, 0, 32'h09, 32'h0, VEC));
        vecs.push_back(mk(F_ADELLD | F_ADES, 32'h80000054, 32'h80000006, 0, 0, 0, 0, 0, 0, 32'h04, 32'h80000006, VEC));
        vecs.push_back(mk(F_ADES | F_ERET, 32'h80000058, 32'h80000007, 0, 0, 0, 0, 0, 0, 32'h05, 32'h80000007, VEC));
        vecs.push_back(mk(9'h0, 32'h80000060, 32'h0, 0, 0, 32'h400, 1, 5'd12, 32'h401, 32'h01, 32'h0, VEC));
        vecs.push_back(mk(F_RI, 32'h80000064, 32'h0, 0, 32'h101, 0, 1, 5'd13, 32'h100, 32'h01, 32'h0, VEC));
        vecs.push_back(mk(F_RI, 32'h80000068, 32'h0, 0, 32'h401, 0, 1, 5'd13, 32'h400, 32'h0a, 32'h0, VEC));
        vecs.push_back(mk(F_RI, 32'h8000006c, 32'h0, 0, 32'h403, 32'h400, 0, 0, 0, 32'h0a, 32'h0, VEC));

        // reset state
        clear_inputs();
        rst = 0;
        repeat (2) step();
        chk("reset_excepttype", excepttype_o, 32'h0);
        chk("reset_flush", {31'h0, flush_o}, 32'h0);
        chk("reset_new_pc", new_pc_o, 32'h0);
        chk("reset_cia", current_inst_addr_o, 32'h0);
        chk("reset_bad_addr", bad_addr_o, 32'h0);
        chk("reset_ds", {31'h0, is_in_delayslot_o}, 32'h0);
        rst = 1;
        step();

        // table-driven single exceptions
        for (int i = 0; i < vecs.size(); i++) begin
            clear_inputs();
            valid_i = 1; pc_i = vecs[i].pc; mem_addr_i = vecs[i].mem; in_delayslot_i = vecs[i].ds;
            {adel_if_i, ri_i, ov_i, trap_i, syscall_i, break_i, adel_ld_i, ades_st_i, eret_i} = vecs[i].flags;
            status_i = vecs[i].status; cause_i = vecs[i].cause;
            cp0_we_i = vecs[i].we; cp0_waddr_i = vecs[i].waddr; cp0_wdata_i = vecs[i].wdata;
            step();
            chk($sformatf("v%0d_excepttype", i), excepttype_o, vecs[i].exp_code);
            chk($sformatf("v%0d_flush", i), {31'h0, flush_o}, 32'h1);
            chk($sformatf("v%0d_cia", i), current_inst_addr_o, vecs[i].pc);
            chk($sformatf("v%0d_bad_addr", i), bad_addr_o, vecs[i].exp_bad);
            chk($sformatf("v%0d_ds", i), {31'h0, is_in_delayslot_o}, {31'h0, vecs[i].ds});
            chk($sformatf("v%0d_new_pc", i), new_pc_o, vecs[i].exp_npc);
            clear_inputs();
            step();
            chk($sformatf("v%0d_pulse_flush", i), {31'h0, flush_o}, 32'h0);
            chk($sformatf("v%0d_pulse_excepttype", i), excepttype_o, 32'h0);
            chk($sformatf("v%0d_hold_cia", i), current_inst_addr_o, vecs[i].pc);
            repeat (3) step();
        end

        // valid instruction with no flags: no flush
        clear_inputs();
        valid_i = 1; pc_i = 32'h80000070;
        step();
        chk("noexc_flush", {31'h0, flush_o}, 32'h0);
        drain_wait();

        // interrupt raised during bubbles, taken on next instruction, beats Ov
        clear_inputs();
        status_i = 32'h401; cause_i = 32'h400;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("intbub_idle%0d_flush", k), {31'h0, flush_o}, 32'h0);
        end
        valid_i = 1; ov_i = 1; pc_i = 32'h80000080;
        step();
        chk("intbub_excepttype", excepttype_o, 32'h01);
        chk("intbub_flush", {31'h0, flush_o}, 32'h1);
        chk("intbub_cia", current_inst_addr_o, 32'h80000080);
        valid_i = 0; ov_i = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("intbub_after%0d_flush", k), {31'h0, flush_o}, 32'h0);
        end
        drain_wait();

        // drain masking: breaks offered right after a syscall are ignored until drain ends
        clear_inputs();
        valid_i = 1; syscall_i = 1; pc_i = 32'h80000090;
        step();
        chk("drain_sys_excepttype", excepttype_o, 32'h08);
        syscall_i = 0; break_i = 1; pc_i = 32'h80000094;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("drain_mask%0d_flush", k), {31'h0, flush_o}, 32'h0);
        end
        step();
        chk("drain_brk_flush", {31'h0, flush_o}, 32'h1);
        chk("drain_brk_excepttype", excepttype_o, 32'h09);
        chk("drain_brk_cia", current_inst_addr_o, 32'h80000094);
        drain_wait();

        // reset during REPORT aborts; block is idle right after release
        clear_inputs();
        valid_i = 1; syscall_i = 1; pc_i = 32'h800000a0;
        step();
        chk("rstrep_flush_before", {31'h0, flush_o}, 32'h1);
        rst = 0;
        #1;
        chk("rstrep_flush", {31'h0, flush_o}, 32'h0);
        chk("rstrep_excepttype", excepttype_o, 32'h0);
        chk("rstrep_new_pc", new_pc_o, 32'h0);
        clear_inputs();
        #1;
        rst = 1;
        step();
        chk("rstrep_release_flush", {31'h0, flush_o}, 32'h0);
        valid_i = 1; break_i = 1; pc_i = 32'h800000a4;
        step();
        chk("rstrep_brk_flush", {31'h0, flush_o}, 32'h1);
        chk("rstrep_brk_excepttype", excepttype_o, 32'h09);
        drain_wait();

        // stalled RI is held off until the stall drops
        clear_inputs();
        valid_i = 1; ri_i = 1; stall_i = 1; pc_i = 32'h800000b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("stall%0d_flush", k), {31'h0, flush_o}, 32'h0);
        end
        stall_i = 0;
        step();
        chk("stall_release_excepttype", excepttype_o, 32'h0a);
        chk("stall_release_flush", {31'h0, flush_o}, 32'h1);
        chk("stall_release_cia", current_inst_addr_o, 32'h800000b0);
        drain_wait();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
